writeback_arbiter: RTL and testbench

Shares the single register-file write port among the `NUM_WB_UNITS` execution units (ALU, load/store, mul, div, …) that complete instructions out of order. Each cycle it grants one `done` requester round-robin and registers the winning result. It maps the instruction ID to its destination register through an inflight table written at issue, then drives the register-file write and the retire notification. It sits between the execution units and the register file / ID-management logic.

---
 rtl/taiga_config.sv | 6 +
 rtl/taiga_types.sv | 18 +
 rtl/rr_priority_select.sv | 38 +++
 rtl/writeback_arbiter.sv | 98 +++++++++
 tb/tb_writeback_arbiter.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/taiga_config.sv
// Build-time sizing shared by the writeback path and its neighbours.
package taiga_config;
  localparam int XLEN               = 32;
  localparam int NUM_WB_UNITS       = 3;
  localparam int MAX_INFLIGHT_COUNT = 4;
endpackage

// File: rtl/taiga_types.sv
// Shared types for instruction IDs, unit indices and writeback payloads.
package taiga_types;
  import taiga_config::*;

  typedef logic [$clog2(MAX_INFLIGHT_COUNT)-1:0] instruction_id_t;
  typedef logic [$clog2(NUM_WB_UNITS)-1:0]       unit_id_t;

  typedef struct packed {
    instruction_id_t  id;
    logic             done;
    logic [XLEN-1:0]  rd;
    logic [31:0]      pc;
  } unit_writeback_t;

  typedef struct packed {
    logic [4:0] rd_addr;
  } inflight_instruction_packet;
endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin one-hot select; priority starts just after last_grant
// and wraps, so N need not be a power of two.
module rr_priority_select #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     requests,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  int               idx_wide;
  logic [IDX_W-1:0] idx;

  always_comb begin
    // NOTE: every output and temporary gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx_wide    = 0;
    idx         = '0;
    for (int k = 1; k <= N; k++) begin
      // last_grant < N, so a single subtraction is enough to wrap.
      idx_wide = int'(last_grant) + k;
      if (idx_wide >= N) idx_wide = idx_wide - N;
      idx = IDX_W'(idx_wide);
      if (!grant_valid && requests[idx]) begin
        grant[idx]  = 1'b1;
        grant_idx   = idx;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Round-robin arbiter for the single register-file write port, with the inflight
// ID->rd table and retire register. Optional trace: TAIGA_WB_CONTENTION_TRACE_EN.
module writeback_arbiter
  import taiga_types::*;
#(
  parameter int NUM_WB_UNITS       = taiga_config::NUM_WB_UNITS,
  parameter int MAX_INFLIGHT_COUNT = taiga_config::MAX_INFLIGHT_COUNT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          issue_valid,
  input  instruction_id_t               issue_id,
  input  logic [4:0]                    issue_rd_addr,
  input  unit_writeback_t               unit_wb [NUM_WB_UNITS],
  output logic [NUM_WB_UNITS-1:0]       wb_ack,
  output logic                          rf_we,
  output logic [4:0]                    rf_rd_addr,
  output logic [taiga_config::XLEN-1:0] rf_data,
  output logic                          retire_valid,
  output instruction_id_t               retire_id,
  output logic [31:0]                   retire_pc,
  output unit_id_t                      retire_unit,
  output logic                          tr_wb_mux_contention
);

  inflight_instruction_packet inflight_table [MAX_INFLIGHT_COUNT];

  logic [NUM_WB_UNITS-1:0] requests;
  unit_id_t                last_grant;
  unit_id_t                grant_idx;
  logic                    grant_valid;
  instruction_id_t         winner_id;
  logic [4:0]              winner_rd_addr;

  always_comb begin
    requests = '0;
    for (int i = 0; i < NUM_WB_UNITS; i++) requests[i] = unit_wb[i].done;
  end

  rr_priority_select #(
    .N     (NUM_WB_UNITS),
    .IDX_W ($bits(unit_id_t))
  ) u_select (
    .requests    (requests),
    .last_grant  (last_grant),
    .grant       (wb_ack),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign winner_id      = unit_wb[grant_idx].id;
  assign winner_rd_addr = inflight_table[winner_id].rd_addr;

  // NOTE: the table is storage, not control state; it has no reset so it can map
  // to plain RAM, and every entry is written at issue before it is ever read.
  always_ff @(posedge clk) begin
    if (issue_valid) inflight_table[issue_id].rd_addr <= issue_rd_addr;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we        <= 1'b0;
      retire_valid <= 1'b0;
      rf_rd_addr   <= '0;
      rf_data      <= '0;
      retire_id    <= '0;
      retire_pc    <= '0;
      retire_unit  <= '0;
      last_grant   <= unit_id_t'(NUM_WB_UNITS - 1);
    end else begin
      rf_we        <= 1'b0;
      retire_valid <= 1'b0;
      if (grant_valid) begin
        // x0 writes are dropped but the ID still retires.
        rf_we        <= (winner_rd_addr != 5'd0);
        retire_valid <= 1'b1;
        rf_rd_addr   <= winner_rd_addr;
        rf_data      <= unit_wb[grant_idx].rd;
        retire_id    <= winner_id;
        retire_pc    <= unit_wb[grant_idx].pc;
        retire_unit  <= grant_idx;
        last_grant   <= grant_idx;
      end
    end
  end

`ifdef TAIGA_WB_CONTENTION_TRACE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tr_wb_mux_contention <= 1'b0;
    else        tr_wb_mux_contention <= ($countones(requests) > 1);
  end
`else
  assign tr_wb_mux_contention = 1'b0;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: reset, single grant, round-robin order,
// x0 suppression, contention, mid-run reset and ID reuse.
module tb_writeback_arbiter;
  import taiga_types::*;

`ifdef TAIGA_WB_CONTENTION_TRACE_EN
  localparam bit TRACE_EN = 1'b1;
`else
  localparam bit TRACE_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            issue_valid;
  instruction_id_t issue_id;
  logic [4:0]      issue_rd_addr;
  unit_writeback_t unit_wb [3];
  logic [2:0]      wb_ack;
  logic            rf_we;
  logic [4:0]      rf_rd_addr;
  logic [31:0]     rf_data;
  logic            retire_valid;
  instruction_id_t retire_id;
  logic [31:0]     retire_pc;
  unit_id_t        retire_unit;
  logic            tr_wb_mux_contention;

  int total = 0;
  int bad   = 0;

  writeback_arbiter dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .issue_valid          (issue_valid),
    .issue_id             (issue_id),
    .issue_rd_addr        (issue_rd_addr),
    .unit_wb              (unit_wb),
    .wb_ack               (wb_ack),
    .rf_we                (rf_we),
    .rf_rd_addr           (rf_rd_addr),
    .rf_data              (rf_data),
    .retire_valid         (retire_valid),
    .retire_id            (retire_id),
    .retire_pc            (retire_pc),
    .retire_unit          (retire_unit),
    .tr_wb_mux_contention (tr_wb_mux_contention)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running want done");
    $fatal(1);
  end

  // Same-ID issue and writeback in one cycle is illegal stimulus.
  always @(negedge clk) begin
    if (issue_valid)
      for (int i = 0; i < 3; i++)
        if (unit_wb[i].done && unit_wb[i].id == issue_id) begin
          bad++;
          $display("FAIL illegal_stimulus: got same id %0d issued and written back, want distinct", issue_id);
        end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_units();
    for (int i = 0; i < 3; i++) unit_wb[i] = '0;
  endtask

  task automatic set_unit(input int u, input int id, input logic [31:0] rd, input logic [31:0] pc);
    unit_wb[u].id   = instruction_id_t'(id);
    unit_wb[u].done = 1'b1;
    unit_wb[u].rd   = rd;
    unit_wb[u].pc   = pc;
  endtask

  task automatic issue(input int id, input int rd);
    issue_valid   = 1'b1;
    issue_id      = instruction_id_t'(id);
    issue_rd_addr = 5'(rd);
    step();
    issue_valid   = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    issue_valid = 1'b0; issue_id = '0; issue_rd_addr = '0;
    clear_units();
    step(); step();
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL reset_rf_we: got %b want 0", rf_we); end
    total++; if (retire_valid !== 1'b0) begin bad++; $display("FAIL reset_retire_valid: got %b want 0", retire_valid); end
    total++; if (tr_wb_mux_contention !== 1'b0) begin bad++; $display("FAIL reset_trace: got %b want 0", tr_wb_mux_contention); end
    total++; if (rf_rd_addr !== 5'd0) begin bad++; $display("FAIL reset_rf_rd_addr: got %0d want 0", rf_rd_addr); end
    total++; if (rf_data !== 32'd0) begin bad++; $display("FAIL reset_rf_data: got %h want 0", rf_data); end
    total++; if (retire_id !== 2'd0) begin bad++; $display("FAIL reset_retire_id: got %0d want 0", retire_id); end
    total++; if (retire_pc !== 32'd0) begin bad++; $display("FAIL reset_retire_pc: got %h want 0", retire_pc); end
    total++; if (retire_unit !== 2'd0) begin bad++; $display("FAIL reset_retire_unit: got %0d want 0", retire_unit); end
    total++; if (wb_ack !== 3'b000) begin bad++; $display("FAIL reset_idle_ack: got %b want 000", wb_ack); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    issue(2, 5);
    set_unit(1, 2, 32'hDEADBEEF, 32'h0000_0100);
    #1;
    total++; if (wb_ack !== 3'b010) begin bad++; $display("FAIL single_ack: got %b want 010", wb_ack); end
    step();
    total++; if (rf_we !== 1'b1) begin bad++; $display("FAIL single_rf_we: got %b want 1", rf_we); end
    total++; if (retire_valid !== 1'b1) begin bad++; $display("FAIL single_valid: got %b want 1", retire_valid); end
    total++; if (rf_rd_addr !== 5'd5) begin bad++; $display("FAIL single_rd_addr: got %0d want 5", rf_rd_addr); end
    total++; if (rf_data !== 32'hDEADBEEF) begin bad++; $display("FAIL single_data: got %h want deadbeef", rf_data); end
    total++; if (retire_id !== 2'd2) begin bad++; $display("FAIL single_id: got %0d want 2", retire_id); end
    total++; if (retire_unit !== 2'd1) begin bad++; $display("FAIL single_unit: got %0d want 1", retire_unit); end
    total++; if (retire_pc !== 32'h100) begin bad++; $display("FAIL single_pc: got %h want 100", retire_pc); end
    clear_units();
    step();
    total++; if (retire_valid !== 1'b0 || rf_we !== 1'b0) begin bad++; $display("FAIL idle_after_single: got valid=%b we=%b want 0/0", retire_valid, rf_we); end
    total++; if (rf_data !== 32'hDEADBEEF) begin bad++; $display("FAIL idle_data_hold: got %h want deadbeef", rf_data); end
  endtask

  task automatic test_round_robin();
    int exp;
    do_reset();
    issue(0, 10); issue(1, 11); issue(2, 12);
    for (int u = 0; u < 3; u++) set_unit(u, u, 32'h1000 + u, 32'h200 + 4 * u);
    for (int k = 0; k < 6; k++) begin
      exp = k % 3;
      #1;
      total++; if (wb_ack !== 3'(1 << exp)) begin bad++; $display("FAIL rr_ack_%0d: got %b want %b", k, wb_ack, 3'(1 << exp)); end
      step();
      total++; if (retire_valid !== 1'b1 || retire_unit !== 2'(exp)) begin bad++; $display("FAIL rr_unit_%0d: got valid=%b unit=%0d want 1/%0d", k, retire_valid, retire_unit, exp); end
      total++; if (rf_rd_addr !== 5'(10 + exp) || rf_data !== 32'h1000 + exp) begin bad++; $display("FAIL rr_write_%0d: got addr=%0d data=%h want %0d/%h", k, rf_rd_addr, rf_data, 10 + exp, 32'h1000 + exp); end
      total++; if (tr_wb_mux_contention !== TRACE_EN) begin bad++; $display("FAIL rr_trace_%0d: got %b want %b", k, tr_wb_mux_contention, TRACE_EN); end
    end
    clear_units();
    step();
  endtask

  task automatic test_x0();
    issue(3, 0);
    set_unit(0, 3, 32'h55, 32'h300);
    #1;
    total++; if (wb_ack !== 3'b001) begin bad++; $display("FAIL x0_ack: got %b want 001", wb_ack); end
    step();
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL x0_rf_we: got %b want 0", rf_we); end
    total++; if (retire_valid !== 1'b1 || retire_id !== 2'd3) begin bad++; $display("FAIL x0_retire: got valid=%b id=%0d want 1/3", retire_valid, retire_id); end
    clear_units();
    step();
  endtask

  // Entry state: last_grant = 0, table[0]=10, table[2]=12.
  task automatic test_contention();
    set_unit(0, 0, 32'hA0, 32'h600);
    set_unit(2, 2, 32'hA2, 32'h608);
    #1;
    total++; if (wb_ack !== 3'b100) begin bad++; $display("FAIL cont_ack_first: got %b want 100", wb_ack); end
    step();
    total++; if (retire_unit !== 2'd2 || rf_rd_addr !== 5'd12) begin bad++; $display("FAIL cont_first: got unit=%0d addr=%0d want 2/12", retire_unit, rf_rd_addr); end
    total++; if (tr_wb_mux_contention !== TRACE_EN) begin bad++; $display("FAIL cont_trace_hi: got %b want %b", tr_wb_mux_contention, TRACE_EN); end
    unit_wb[2] = '0;
    #1;
    total++; if (wb_ack !== 3'b001) begin bad++; $display("FAIL cont_ack_second: got %b want 001", wb_ack); end
    step();
    total++; if (retire_unit !== 2'd0 || rf_data !== 32'hA0) begin bad++; $display("FAIL cont_second: got unit=%0d data=%h want 0/a0", retire_unit, rf_data); end
    total++; if (tr_wb_mux_contention !== 1'b0) begin bad++; $display("FAIL cont_trace_lo: got %b want 0", tr_wb_mux_contention); end
    clear_units();
    step();
  endtask

  // Entry state: last_grant = 0, so unit 2 alone is granted.
  task automatic test_reset_mid();
    set_unit(2, 2, 32'hBB, 32'h400);
    step();
    total++; if (retire_valid !== 1'b1 || rf_we !== 1'b1) begin bad++; $display("FAIL mid_pre: got valid=%b we=%b want 1/1", retire_valid, rf_we); end
    rst_n = 1'b0;
    #1;
    total++; if (rf_we !== 1'b0 || retire_valid !== 1'b0) begin bad++; $display("FAIL mid_async_clear: got we=%b valid=%b want 0/0", rf_we, retire_valid); end
    total++; if (rf_data !== 32'd0 || retire_unit !== 2'd0) begin bad++; $display("FAIL mid_async_data: got data=%h unit=%0d want 0/0", rf_data, retire_unit); end
    step();
    rst_n = 1'b1;
    #1;
    total++; if (wb_ack !== 3'b100) begin bad++; $display("FAIL mid_release_ack: got %b want 100", wb_ack); end
    step();
    total++; if (retire_valid !== 1'b1 || retire_unit !== 2'd2 || rf_data !== 32'hBB) begin bad++; $display("FAIL mid_release_grant: got valid=%b unit=%0d data=%h want 1/2/bb", retire_valid, retire_unit, rf_data); end
    // Two pending requests across reset restart from unit 0.
    set_unit(0, 0, 32'hC0, 32'h700);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    total++; if (wb_ack !== 3'b001) begin bad++; $display("FAIL mid_restart_order: got %b want 001", wb_ack); end
    clear_units();
    step();
  endtask

  task automatic test_id_reuse();
    issue(1, 7);
    set_unit(0, 1, 32'h7777, 32'h500);
    issue_valid = 1'b1; issue_id = 2'd3; issue_rd_addr = 5'd17;
    step();
    issue_valid = 1'b0;
    total++; if (rf_rd_addr !== 5'd7 || retire_id !== 2'd1) begin bad++; $display("FAIL reuse_first: got addr=%0d id=%0d want 7/1", rf_rd_addr, retire_id); end
    clear_units();
    issue(1, 9);
    set_unit(0, 1, 32'h9999, 32'h504);
    step();
    total++; if (rf_rd_addr !== 5'd9 || rf_data !== 32'h9999 || rf_we !== 1'b1) begin bad++; $display("FAIL reuse_second: got addr=%0d data=%h we=%b want 9/9999/1", rf_rd_addr, rf_data, rf_we); end
    set_unit(0, 3, 32'h3333, 32'h508);
    step();
    total++; if (rf_rd_addr !== 5'd17 || retire_id !== 2'd3) begin bad++; $display("FAIL parallel_issue: got addr=%0d id=%0d want 17/3", rf_rd_addr, retire_id); end
    clear_units();
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_x0();
    test_contention();
    test_reset_mid();
    test_id_reuse();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
